// File: rtl/test_018_pkg.sv
// ============================================================================
// Module      : test_018_pkg
// Description : Shared constants and state encoding for the test_018
//               self-checking memory/accumulate block.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package test_018_pkg;

  // Memory geometry and sequence step
  localparam int DEPTH = 16;
  localparam int AW    = 4;
  localparam int STEP  = 3;

  // Expected results for test_idx = 0: sum(3*i, i=0..15) and 3*15
  localparam logic [31:0] EXP_SUM_BASE  = 32'd360;
  localparam logic [31:0] EXP_LAST_BASE = 32'd45;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_INIT = 3'd1,
    ST_WR   = 3'd2,
    ST_RD   = 3'd3,
    ST_CHK  = 3'd4
  } state_t;

endpackage : test_018_pkg

`default_nettype wire

// File: rtl/test_018_ram.sv
// ============================================================================
// Module      : test_018_ram
// Description : DEPTH x 32 single-port RAM, synchronous write, registered
//               read with one cycle of latency. Contents are never reset.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module test_018_ram
  import test_018_pkg::*;
(
  input  logic          clk,
  input  logic          i_we,
  input  logic [AW-1:0] i_addr,
  input  logic [31:0]   i_wdata,
  output logic [31:0]   o_rdata
);

  logic [31:0] r_mem [DEPTH];
  logic [31:0] r_rdata;

  // Write port plus registered read of the same address (read-before-write)
  always_ff @(posedge clk) begin
    if (i_we) begin
      r_mem[i_addr] <= i_wdata;
    end
    r_rdata <= r_mem[i_addr];
  end

  assign o_rdata = r_rdata;

endmodule : test_018_ram

`default_nettype wire

// File: rtl/test_018.sv
// ============================================================================
// Module      : test_018
// Description : Self-checking compute block. On a test_req call it fills a
//               16-entry RAM with 3*i + idx, reads it back, accumulates the
//               words and reports whether sum and last word match the
//               closed-form expectation.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module test_018
  import test_018_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] test_idx,
  input  logic        test_req,
  output logic        test_busy,
  output logic        test_return
);

  state_t      r_state;
  state_t      w_next;

  // Index counter is one bit wider than the address so RD can reach DEPTH
  logic [4:0]  r_i;
  logic [31:0] r_sum;
  logic [31:0] r_idx;
  logic [31:0] r_last;
  logic        r_busy;
  logic        r_ret;

  logic        w_we;
  logic [AW-1:0] w_addr;
  logic [31:0] w_wdata;
  logic [31:0] w_rdata;
  logic        w_last_wr;
  logic        w_last_rd;
  logic        w_pass;

  assign w_last_wr = (r_i == 5'(DEPTH - 1));
  assign w_last_rd = (r_i == 5'(DEPTH));
  assign w_we      = (r_state == ST_WR);
  assign w_addr    = r_i[AW-1:0];
  assign w_wdata   = r_idx + ({27'd0, r_i} * 32'(STEP));

  // Closed-form check: sum = 360 + 16*idx, last = 45 + idx (mod 2^32)
  assign w_pass = (r_sum  == (EXP_SUM_BASE + (r_idx << 4))) &&
                  (r_last == (EXP_LAST_BASE + r_idx));

  test_018_ram u_ram (
    .clk     (clk),
    .i_we    (w_we),
    .i_addr  (w_addr),
    .i_wdata (w_wdata),
    .o_rdata (w_rdata)
  );

  // State register
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // Next-state logic; requests are only honoured in IDLE
  always_comb begin
    w_next = r_state;
    case (r_state)
      ST_IDLE: if (test_req)  w_next = ST_INIT;
      ST_INIT:                w_next = ST_WR;
      ST_WR:   if (w_last_wr) w_next = ST_RD;
      ST_RD:   if (w_last_rd) w_next = ST_CHK;
      ST_CHK:                 w_next = ST_IDLE;
      default:                w_next = ST_IDLE;
    endcase
  end

  // Datapath: argument latch, loop counter, accumulator, result register
  always_ff @(posedge clk) begin
    if (reset) begin
      r_i    <= '0;
      r_sum  <= '0;
      r_idx  <= '0;
      r_last <= '0;
      r_busy <= 1'b0;
      r_ret  <= 1'b0;
    end else begin
      // Busy mirrors "not heading to IDLE", so it drops on the CHK exit edge
      r_busy <= (w_next != ST_IDLE);
      case (r_state)
        ST_IDLE: begin
          if (test_req) begin
            r_idx <= test_idx;
          end
        end
        ST_INIT: begin
          r_i   <= '0;
          r_sum <= '0;
        end
        ST_WR: begin
          r_i <= w_last_wr ? 5'd0 : r_i + 5'd1;
        end
        ST_RD: begin
          // Read data lags the address by one cycle, so skip the first slot
          if (r_i != 5'd0) begin
            r_sum <= r_sum + w_rdata;
          end
          if (w_last_rd) begin
            r_last <= w_rdata;
            r_i    <= '0;
          end else begin
            r_i <= r_i + 5'd1;
          end
        end
        ST_CHK: begin
          r_ret <= w_pass;
        end
        default: begin
          r_i <= '0;
        end
      endcase
    end
  end

  assign test_busy   = r_busy;
  assign test_return = r_ret;

endmodule : test_018

`default_nettype wire

// File: tb/tb_test_018.sv
// ============================================================================
// Module      : tb_test_018
// Description : Self-checking bench for test_018. A call-level model predicts
//               busy/return every cycle; directed sequences add literal checks.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_test_018;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [31:0] test_idx = 32'd0;
  logic        test_req = 1'b0;
  logic        test_busy;
  logic        test_return;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  test_018 dut (
    .clk         (clk),
    .reset       (reset),
    .test_idx    (test_idx),
    .test_req    (test_req),
    .test_busy   (test_busy),
    .test_return (test_return)
  );

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  // Call-level model: memory filled with 3*i + idx, summed and last word taken
  function automatic logic [31:0] model_sum(input logic [31:0] idx);
    logic [31:0] mem [16];
    logic [31:0] s;
    s = 32'd0;
    for (int k = 0; k < 16; k++) mem[k] = 32'(3 * k) + idx;
    for (int k = 0; k < 16; k++) s = s + mem[k];
    return s;
  endfunction

  function automatic logic [31:0] model_last(input logic [31:0] idx);
    return 32'(3 * 15) + idx;
  endfunction

  function automatic logic model_pass(input logic [31:0] idx);
    return (model_sum(idx) == 32'd360 + idx * 32'd16) &&
           (model_last(idx) == 32'd45 + idx);
  endfunction

  // A call occupies 35 busy cycles; result lands when the count expires
  int          m_cnt = 0;
  logic [31:0] m_idx = 32'd0;
  logic        m_ret = 1'b0;
  bit          m_on  = 1'b0;

  always @(posedge clk) begin
    if (reset) begin
      m_cnt = 0;
      m_ret = 1'b0;
      m_idx = 32'd0;
    end else if (m_cnt == 0) begin
      if (test_req) begin
        m_cnt = 35;
        m_idx = test_idx;
      end
    end else begin
      m_cnt--;
      if (m_cnt == 0) m_ret = model_pass(m_idx);
    end
  end

  always @(negedge clk) begin
    if (m_on) begin
      check("model_busy", {31'd0, test_busy}, {31'd0, (m_cnt != 0)});
      check("model_return", {31'd0, test_return}, {31'd0, m_ret});
    end
  end

  task automatic drive(input logic req, input logic [31:0] idx);
    @(posedge clk);
    #1;
    test_req = req;
    test_idx = idx;
  endtask

  // Wait for busy to rise, then count its high cycles
  task automatic busy_len(input string nm, input int exp_len);
    int to = 0;
    int n  = 0;
    @(negedge clk);
    while (test_busy !== 1'b1 && to < 10) begin
      @(negedge clk);
      to++;
    end
    while (test_busy === 1'b1 && n < 100) begin
      @(negedge clk);
      n++;
    end
    check({nm, "_len"}, n, exp_len);
  endtask

  task automatic wait_idle(input string nm);
    int to = 0;
    @(negedge clk);
    while (test_busy !== 1'b0 && to < 100) begin
      @(negedge clk);
      to++;
    end
    check({nm, "_idle"}, {31'd0, test_busy}, 32'd0);
  endtask

  initial begin
    // Model sanity against hand-computed values
    check("msum_0",    model_sum(32'h0),         32'd360);
    check("mlast_0",   model_last(32'h0),        32'd45);
    check("msum_10",   model_sum(32'h10),        32'd616);
    check("mlast_10",  model_last(32'h10),       32'd61);
    check("msum_ff",   model_sum(32'hFFFF_FFFF), 32'h0000_0158);
    check("mlast_ff",  model_last(32'hFFFF_FFFF),32'h0000_002C);

    // Reset, then idle for 100+ cycles with no request
    repeat (3) @(posedge clk);
    m_on = 1'b1;
    #1 reset = 1'b0;
    repeat (120) @(negedge clk);
    check("idle_busy", {31'd0, test_busy}, 32'd0);
    check("idle_ret",  {31'd0, test_return}, 32'd0);

    // idx=0 with req held: 35 busy cycles, pass, 1-cycle gap before next call
    drive(1'b1, 32'h0);
    busy_len("call0", 35);
    check("ret0", {31'd0, test_return}, 32'd1);
    @(negedge clk);
    check("gap_one", {31'd0, test_busy}, 32'd1);
    // Change idx and toggle req while busy: call keeps latched idx 0
    for (int k = 0; k < 6; k++) drive(k[0], 32'hDEAD_0000 + 32'(k));
    drive(1'b0, 32'h1234_5678);
    wait_idle("call0b");
    check("ret0b", {31'd0, test_return}, 32'd1);

    // idx=0x10 single-cycle pulse; busy must stay low afterwards
    drive(1'b1, 32'h10);
    drive(1'b0, 32'h10);
    busy_len("call10", 35);
    check("ret10", {31'd0, test_return}, 32'd1);
    repeat (20) @(negedge clk);
    check("after10", {31'd0, test_busy}, 32'd0);

    // idx=0xFFFF_FFFF: wrap-around arithmetic
    drive(1'b1, 32'hFFFF_FFFF);
    drive(1'b0, 32'h0);
    busy_len("callff", 35);
    check("retff", {31'd0, test_return}, 32'd1);

    // Reset for 6 cycles in the middle of a call
    drive(1'b1, 32'h5);
    drive(1'b0, 32'h5);
    repeat (20) @(negedge clk);
    check("mid_busy", {31'd0, test_busy}, 32'd1);
    @(posedge clk);
    #1 reset = 1'b1;
    repeat (6) @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    check("rst_busy", {31'd0, test_busy}, 32'd0);
    check("rst_ret",  {31'd0, test_return}, 32'd0);
    drive(1'b1, 32'h7);
    drive(1'b0, 32'h7);
    busy_len("call7", 35);
    check("ret7", {31'd0, test_return}, 32'd1);

    // Reset and req together: call starts on first non-reset cycle
    @(posedge clk);
    #1;
    reset    = 1'b1;
    test_req = 1'b1;
    test_idx = 32'h9;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    busy_len("call9", 35);
    check("ret9", {31'd0, test_return}, 32'd1);
    drive(1'b0, 32'h0);
    wait_idle("call9b");
    check("ret9b", {31'd0, test_return}, 32'd1);

    repeat (5) @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule : tb_test_018

`default_nettype wire
